clk_switch_seq: RTL and testbench

//  Glitch-safe sequencer for the rst_clk_ctrl clock tree. Runs on the always-on 8 MHz ROSC clock.

---
 rtl/clk_switch_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_clk_switch_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_seq.sv
// clk_switch_seq
//   Glitch-safe sequencer for the rst_clk_ctrl clock tree. Runs on the
//   always-on 8 MHz ROSC clock and walks the clock muxes through a fixed safe
//   order: PLL up and settled, park on 8 MHz, reconfigure, release, then PLL
//   down when it is no longer used.
//
// Optional feature macro: CLKSEQ_PLL_LOCK_EN
//   Defined   -> adds pll_lock input (2-flop synchronised) and err output.
//                PLL_WAIT ends on synced lock; a PLL_SETTLE timeout aborts
//                the sequence with err=1.
//   Undefined -> fixed PLL_SETTLE wait, no pll_lock/err ports.
//
// Ports
//   clk, rst_n            : sequencer clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_src/div/trim      : target source, divider, PLL trim
//   done, busy            : completion pulse, ~req_ready
//   cur_src, cur_div      : committed configuration
//   pll_en, pll_trim      : PLL controls
//   sel_8mhz/xclk/pll     : mux selects
//   clk_div               : divider select
//   pll_lock, err         : only with CLKSEQ_PLL_LOCK_EN
module clk_switch_seq #(
  parameter int PLL_SETTLE = 1024,
  parameter int MUX_SETTLE = 8,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [1:0] req_div,
  input  logic [1:0] req_trim,
  output logic       done,
  output logic       busy,
  output logic [1:0] cur_src,
  output logic [1:0] cur_div,
  output logic       pll_en,
  output logic [1:0] pll_trim,
  output logic       sel_8mhz,
  output logic       sel_xclk,
  output logic       sel_pll,
  output logic [1:0] clk_div
`ifdef CLKSEQ_PLL_LOCK_EN
  ,
  input  logic       pll_lock,
  output logic       err
`endif
);

  localparam logic [1:0] SRC_PLL  = 2'd1;
  localparam logic [1:0] SRC_XCLK = 2'd2;
  localparam logic [1:0] SRC_8M   = 2'd3;

  localparam logic [CNT_W-1:0] PLL_LOAD = CNT_W'(PLL_SETTLE - 1);
  localparam logic [CNT_W-1:0] MUX_LOAD = CNT_W'(MUX_SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLL_WAIT,
    S_PARK,
    S_CFG,
    S_RELEASE,
    S_PLL_OFF,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       tgt_src;
  logic [1:0]       tgt_div;
  logic             cnt_zero;
  logic             pll_up;
  logic             pll_fail;

  assign cnt_zero = (cnt == '0);

`ifdef CLKSEQ_PLL_LOCK_EN
  logic [1:0] lock_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync <= 2'b00;
    else        lock_sync <= {lock_sync[0], pll_lock};
  end

  // Lock wins over a simultaneous timeout; timeout only if lock never seen.
  assign pll_up   = lock_sync[1];
  assign pll_fail = cnt_zero & ~lock_sync[1];
`else
  assign pll_up   = cnt_zero;
  assign pll_fail = 1'b0;
`endif

  // Every control output is assigned only on the transition into a state,
  // so nothing moves while the FSM sits in IDLE or counts down a wait.
  // sel_xclk/sel_pll/clk_div are only written on CFG entry, which is always
  // preceded by sel_8mhz=1, so the final mux never sees a switching input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tgt_src   <= SRC_8M;
      tgt_div   <= 2'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_src   <= SRC_8M;
      cur_div   <= 2'd0;
      pll_en    <= 1'b0;
      pll_trim  <= 2'd0;
      sel_8mhz  <= 1'b1;
      sel_xclk  <= 1'b0;
      sel_pll   <= 1'b0;
      clk_div   <= 2'd0;
`ifdef CLKSEQ_PLL_LOCK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tgt_src   <= req_src;
            tgt_div   <= req_div;
`ifdef CLKSEQ_PLL_LOCK_EN
            err       <= 1'b0;
`endif
            if (req_src == cur_src && req_div == cur_div) begin
              if (req_src == SRC_PLL) pll_trim <= req_trim;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (req_src == SRC_PLL && !pll_en) begin
              pll_en   <= 1'b1;
              pll_trim <= req_trim;
              cnt      <= PLL_LOAD;
              state    <= S_PLL_WAIT;
            end else begin
              // PLL already running: trim is retuned while still parked.
              if (req_src == SRC_PLL) pll_trim <= req_trim;
              if (!sel_8mhz) begin
                sel_8mhz <= 1'b1;
                cnt      <= MUX_LOAD;
                state    <= S_PARK;
              end else begin
                if (req_src != SRC_8M) begin
                  sel_pll  <= (req_src == SRC_PLL);
                  sel_xclk <= (req_src == SRC_XCLK);
                end
                clk_div <= req_div;
                cnt     <= MUX_LOAD;
                state   <= S_CFG;
              end
            end
          end
        end

        S_PLL_WAIT: begin
          if (pll_up) begin
            if (!sel_8mhz) begin
              sel_8mhz <= 1'b1;
              cnt      <= MUX_LOAD;
              state    <= S_PARK;
            end else begin
              sel_pll  <= 1'b1;
              sel_xclk <= 1'b0;
              clk_div  <= tgt_div;
              cnt      <= MUX_LOAD;
              state    <= S_CFG;
            end
          end else if (pll_fail) begin
            // Abort: PLL off, selects and committed config left alone.
            pll_en <= 1'b0;
            done   <= 1'b1;
`ifdef CLKSEQ_PLL_LOCK_EN
            err    <= 1'b1;
`endif
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_PARK: begin
          if (cnt_zero) begin
            if (tgt_src != SRC_8M) begin
              sel_pll  <= (tgt_src == SRC_PLL);
              sel_xclk <= (tgt_src == SRC_XCLK);
            end
            clk_div <= tgt_div;
            cnt     <= MUX_LOAD;
            state   <= S_CFG;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_CFG: begin
          if (cnt_zero) begin
            if (tgt_src == SRC_8M) begin
              if (tgt_src != SRC_PLL) pll_en <= 1'b0;
              state <= S_PLL_OFF;
            end else begin
              sel_8mhz <= 1'b0;
              cnt      <= MUX_LOAD;
              state    <= S_RELEASE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RELEASE: begin
          if (cnt_zero) begin
            if (tgt_src != SRC_PLL) pll_en <= 1'b0;
            state <= S_PLL_OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_PLL_OFF: begin
          cur_src <= tgt_src;
          cur_div <= tgt_div;
          done    <= 1'b1;
          state   <= S_DONE;
        end

        S_DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_seq.sv
// tb_clk_switch_seq
//   Directed bench for clk_switch_seq with PLL_SETTLE=16, MUX_SETTLE=4.
//   Cycle k of a sequence is the k-th clock period after the edge that
//   accepted the request; outputs are sampled 1 ns after each rising edge.
module tb_clk_switch_seq;

  localparam int P = 16;
  localparam int M = 4;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_src;
  logic [1:0] req_div;
  logic [1:0] req_trim;
  logic       done;
  logic       busy;
  logic [1:0] cur_src;
  logic [1:0] cur_div;
  logic       pll_en;
  logic [1:0] pll_trim;
  logic       sel_8mhz;
  logic       sel_xclk;
  logic       sel_pll;
  logic [1:0] clk_div;
`ifdef CLKSEQ_PLL_LOCK_EN
  logic       pll_lock;
  logic       err;
  int         lock_at;
`endif

  int checks;
  int errors;
  int inv_viol;

  int done_cyc;
  int pll_rise;
  int pll_fall;
  int xclk_rise;
  int m8_rise;
  int m8_fall;
  int pen_fall;
  int toggles;
  int accept_wait;
  logic       c1_pll_en;
  logic [1:0] c1_trim;
  logic       p8, px, pp, pe;
  logic [1:0] pd;

  clk_switch_seq #(
    .PLL_SETTLE(P),
    .MUX_SETTLE(M),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_src(req_src),
    .req_div(req_div),
    .req_trim(req_trim),
    .done(done),
    .busy(busy),
    .cur_src(cur_src),
    .cur_div(cur_div),
    .pll_en(pll_en),
    .pll_trim(pll_trim),
    .sel_8mhz(sel_8mhz),
    .sel_xclk(sel_xclk),
    .sel_pll(sel_pll),
    .clk_div(clk_div)
`ifdef CLKSEQ_PLL_LOCK_EN
    ,
    .pll_lock(pll_lock),
    .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Select lines behind the final mux must stay frozen while it is not parked.
  logic       m_8, m_x, m_p;
  logic [1:0] m_d;
  initial inv_viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!m_8 && (sel_xclk !== m_x || sel_pll !== m_p || clk_div !== m_d))
        inv_viol++;
    end
    m_8 = sel_8mhz;
    m_x = sel_xclk;
    m_p = sel_pll;
    m_d = clk_div;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_output({pfx, "_sel_8mhz"}, sel_8mhz, 1);
    check_output({pfx, "_sel_xclk"}, sel_xclk, 0);
    check_output({pfx, "_sel_pll"}, sel_pll, 0);
    check_output({pfx, "_pll_en"}, pll_en, 0);
    check_output({pfx, "_pll_trim"}, pll_trim, 0);
    check_output({pfx, "_clk_div"}, clk_div, 0);
    check_output({pfx, "_cur_src"}, cur_src, 3);
    check_output({pfx, "_cur_div"}, cur_div, 0);
    check_output({pfx, "_done"}, done, 0);
    check_output({pfx, "_req_ready"}, req_ready, 1);
    check_output({pfx, "_busy"}, busy, 0);
  endtask

  task automatic track(input int cyc);
    if (sel_pll && !pp && pll_rise == 0) pll_rise = cyc;
    if (!sel_pll && pp && pll_fall == 0) pll_fall = cyc;
    if (sel_xclk && !px && xclk_rise == 0) xclk_rise = cyc;
    if (sel_8mhz && !p8 && m8_rise == 0) m8_rise = cyc;
    if (!sel_8mhz && p8 && m8_fall == 0) m8_fall = cyc;
    if (!pll_en && pe && pen_fall == 0) pen_fall = cyc;
    toggles += int'(sel_8mhz != p8) + int'(sel_xclk != px) +
               int'(sel_pll != pp) + int'(clk_div != pd);
    p8 = sel_8mhz;
    px = sel_xclk;
    pp = sel_pll;
    pd = clk_div;
    pe = pll_en;
  endtask

  // Issue one request, run the sequence to its done pulse (bounded) and
  // record when each control line moved. Returns at the done cycle.
  task automatic apply_stimulus(input logic [1:0] s, input logic [1:0] d,
                                input logic [1:0] t, input bit noise);
    int cyc;
    req_src   = s;
    req_div   = d;
    req_trim  = t;
    req_valid = 1'b1;
    accept_wait = 0;
    while (!req_ready && accept_wait < 100) begin
      tick();
      accept_wait++;
    end
    p8 = sel_8mhz; px = sel_xclk; pp = sel_pll; pd = clk_div; pe = pll_en;
    pll_rise = 0; pll_fall = 0; xclk_rise = 0; m8_rise = 0; m8_fall = 0;
    pen_fall = 0; toggles = 0;
`ifdef CLKSEQ_PLL_LOCK_EN
    pll_lock = 1'b0;
`endif
    tick();
    req_valid = 1'b0;
    cyc = 1;
    c1_pll_en = pll_en;
    c1_trim   = pll_trim;
    track(cyc);
    while (!done && cyc < 100) begin
      if (noise) begin
        req_valid = cyc[0];
        req_src   = 2'd0;
        req_div   = 2'd2;
        req_trim  = 2'd1;
      end
`ifdef CLKSEQ_PLL_LOCK_EN
      pll_lock = (lock_at > 0 && cyc >= lock_at);
`endif
      tick();
      cyc++;
      track(cyc);
    end
    done_cyc = cyc;
    check_output("done_seen", done, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_src   = 2'd0;
    req_div   = 2'd0;
    req_trim  = 2'd0;
`ifdef CLKSEQ_PLL_LOCK_EN
    pll_lock  = 1'b0;
    lock_at   = 14;
`endif
    repeat (3) tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // 1: ROSC/8MHz -> PLL /1 trim 2. Already parked, so PARK is skipped:
    //    PLL_WAIT 1..16, CFG 17..20, RELEASE 21..24, PLL_OFF 25, DONE 26.
    $display("[TB] step 1: bring up PLL");
    apply_stimulus(2'd1, 2'd0, 2'd2, 1'b0);
    check_output("t1_pll_en_c1", c1_pll_en, 1);
    check_output("t1_trim_c1", c1_trim, 2);
    check_output("t1_sel_pll_rise", pll_rise, P + 1);
    check_output("t1_8mhz_fall", m8_fall, P + M + 1);
    check_output("t1_done_cyc", done_cyc, P + 2 * M + 2);
    check_output("t1_cur_src", cur_src, 1);
    check_output("t1_busy_at_done", busy, 1);
    tick();
    check_output("t1_done_pulse", done, 0);
    check_output("t1_ready_idle", req_ready, 1);

    // 2: PLL -> XCLK /8. PARK 1..4, CFG 5..8, RELEASE 9..12, PLL_OFF 13, DONE 14.
    $display("[TB] step 2: PLL to XCLK");
    apply_stimulus(2'd2, 2'd3, 2'd0, 1'b0);
    check_output("t2_8mhz_rise", m8_rise, 1);
    check_output("t2_sel_pll_fall", pll_fall, M + 1);
    check_output("t2_xclk_rise", xclk_rise, M + 1);
    check_output("t2_8mhz_fall", m8_fall, 2 * M + 1);
    check_output("t2_pll_en_fall", pen_fall, 3 * M + 1);
    check_output("t2_done_cyc", done_cyc, 3 * M + 2);
    check_output("t2_clk_div", clk_div, 3);
    check_output("t2_cur", {cur_src, cur_div}, 4'b1011);
    tick();

    // 3: repeat current target; trim is not touched for a non-PLL source.
    $display("[TB] step 3: repeat target");
    apply_stimulus(2'd2, 2'd3, 2'd1, 1'b0);
    check_output("t3_done_cyc", done_cyc, 1);
    check_output("t3_toggles", toggles, 0);
    check_output("t3_pll_trim", pll_trim, 2);
    tick();

    // 5: XCLK -> 8MHz /2 with request noise while busy. PARK 1..4,
    //    CFG 5..8, no RELEASE, PLL_OFF 9, DONE 10; sel_xclk left as is.
    $display("[TB] step 5: noise while busy");
    apply_stimulus(2'd3, 2'd1, 2'd0, 1'b1);
    check_output("t5_done_cyc", done_cyc, 2 * M + 2);
    check_output("t5_cur", {cur_src, cur_div}, 4'b1101);
    check_output("t5_clk_div", clk_div, 1);
    check_output("t5_sel_xclk_kept", sel_xclk, 1);
    check_output("t5_sel_8mhz", sel_8mhz, 1);
    check_output("t5_8mhz_fall", m8_fall, 0);

    // Request held across done: accepted on the first IDLE cycle.
    // 8MHz -> ROSC /4: CFG 1..4, RELEASE 5..8, PLL_OFF 9, DONE 10.
    apply_stimulus(2'd0, 2'd2, 2'd0, 1'b0);
    check_output("t5b_accept_wait", accept_wait, 1);
    check_output("t5b_done_cyc", done_cyc, 2 * M + 2);
    check_output("t5b_8mhz_fall", m8_fall, M + 1);
    check_output("t5b_sel", {sel_8mhz, sel_xclk, sel_pll}, 3'b000);
    check_output("t5b_cur", {cur_src, cur_div}, 4'b0010);
    tick();

    // 4: reset during CFG of ROSC -> XCLK /2 (CFG occupies cycles 5..8).
    $display("[TB] step 4: reset mid-sequence");
    req_src   = 2'd2;
    req_div   = 2'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check_output("t4_in_cfg_xclk", sel_xclk, 1);
    check_output("t4_in_cfg_div", clk_div, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t4_async");
    #2 rst_n = 1'b1;
    tick();
    check_output("t4_ready_after", req_ready, 1);

`ifdef CLKSEQ_PLL_LOCK_EN
    // 6a: lock never rises -> abort after PLL_SETTLE with err.
    $display("[TB] step 6: PLL lock");
    lock_at = 0;
    apply_stimulus(2'd1, 2'd1, 2'd3, 1'b0);
    check_output("t6a_done_cyc", done_cyc, P + 1);
    check_output("t6a_err", err, 1);
    check_output("t6a_pll_en", pll_en, 0);
    check_output("t6a_cur_src", cur_src, 3);
    check_output("t6a_toggles", toggles, 0);
    tick();
    // 6b: lock at cycle 5 -> synced high in cycle 7 -> CFG visible cycle 8.
    lock_at = 5;
    apply_stimulus(2'd1, 2'd1, 2'd1, 1'b0);
    check_output("t6b_sel_pll_rise", pll_rise, 8);
    check_output("t6b_done_cyc", done_cyc, 8 + 2 * M + 1);
    check_output("t6b_err", err, 0);
    check_output("t6b_cur_src", cur_src, 1);
    tick();
`endif

    check_output("sel_invariant", inv_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
